// File: rtl/swap_unpack.sv
// swap_unpack: collects a swapped nibble triple (a1, b1, c1) from a serial
// valid/ready stream and presents the restored (a, b, c) = (b1, a1, c1)
// through a registered valid/ready output, counting delivered triples.
module swap_unpack #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   frame_cnt
);

  typedef enum logic [1:0] {
    GET_A1 = 2'd0,
    GET_B1 = 2'd1,
    GET_C1 = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] hold_a1_q, hold_a1_d;
  logic [W-1:0] hold_b1_q, hold_b1_d;
  logic [W-1:0] out_a_q, out_a_d;
  logic [W-1:0] out_b_q, out_b_d;
  logic [W-1:0] out_c_q, out_c_d;
  logic         out_valid_q, out_valid_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;

  logic accept;
  logic deliver;
  logic load;

  // Input readiness: flush blocks acceptance; the last word waits for the
  // output register to be free (or freed on this same edge).
  always_comb begin
    in_ready = 1'b1;
    if (flush) begin
      in_ready = 1'b0;
    end else if (state_q == GET_C1) begin
      in_ready = !out_valid_q || out_ready;
    end
  end

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid_q && out_ready;
  assign load    = accept && (state_q == GET_C1);

  // Next-state for the collection FSM, the hold registers and the output slot.
  always_comb begin
    state_d     = state_q;
    hold_a1_d   = hold_a1_q;
    hold_b1_d   = hold_b1_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;

    if (flush) begin
      state_d   = GET_A1;
      hold_a1_d = '0;
      hold_b1_d = '0;
    end else if (accept) begin
      unique case (state_q)
        GET_A1: begin
          hold_a1_d = in_data;
          state_d   = GET_B1;
        end
        GET_B1: begin
          hold_b1_d = in_data;
          state_d   = GET_C1;
        end
        GET_C1: begin
          state_d = GET_A1;
        end
        default: state_d = GET_A1;
      endcase
    end

    // A load on a delivery edge keeps out_valid high with the new triple.
    if (load) begin
      out_a_d     = hold_b1_q;
      out_b_d     = hold_a1_q;
      out_c_d     = in_data;
      out_valid_d = 1'b1;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end

    if (deliver) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GET_A1;
      hold_a1_q   <= '0;
      hold_b1_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_a1_q   <= hold_a1_d;
      hold_b1_q   <= hold_b1_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_swap_unpack.sv
// Scoreboard bench for swap_unpack: stimulus pushes expected restored
// triples; a monitor pops and compares on every output handshake.
module tb_swap_unpack;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_a, out_b, out_c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] frame_cnt;

  swap_unpack #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned del_cnt  = 0;
  int unsigned exp_cnt  = 0;
  int unsigned last_del = 0;
  bit          have_prev = 0;
  bit          gap_en    = 0;
  logic [11:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: on each negedge where a handshake will occur at the next edge,
  // compare the presented triple and counter with the scoreboard.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt   = 0;
        have_prev = 0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {20'd0, out_a, out_b, out_c}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("triple", {20'd0, out_a, out_b, out_c}, {20'd0, e});
        end
        chk("frame_cnt_at_delivery", {24'd0, frame_cnt}, exp_cnt % 256);
        if (gap_en) begin
          if (have_prev) chk("delivery_gap", cyc - last_del, 3);
          last_del  = cyc;
          have_prev = 1;
        end
        exp_cnt = exp_cnt + 1;
        del_cnt = del_cnt + 1;
      end
    end
  end

  task automatic send_word(input logic [3:0] w);
    int unsigned n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int unsigned t0, d0;
    logic [3:0] a, b, c;
    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    chk("reset_out", {20'd0, out_a, out_b, out_c}, 0);
    chk("reset_valid_cnt", {23'd0, out_valid, frame_cnt}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic restore with one-cycle latency.
    out_ready = 1'b1;
    send_word(4'h3);
    send_word(4'h5);
    exp_q.push_back({4'h5, 4'h3, 4'h9});
    send_word(4'h9);
    in_valid = 1'b0;
    chk("basic_latency", {27'd0, out_valid, out_a}, {27'd0, 1'b1, 4'h5});
    chk("basic_bc", {24'd0, out_b, out_c}, {24'd0, 4'h3, 4'h9});
    @(posedge clk);
    #1;
    chk("basic_cnt", {23'd0, out_valid, frame_cnt}, {23'd0, 1'b0, 8'd1});

    // Backpressure: one triple held while the next is collected.
    out_ready = 1'b0;
    send_word(4'h1);
    send_word(4'h2);
    exp_q.push_back({4'h2, 4'h1, 4'h3});
    send_word(4'h3);
    send_word(4'hA);
    send_word(4'hB);
    in_data  = 4'hC;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_hold", {19'd0, out_valid, out_a, out_b, out_c}, {19'd0, 1'b1, 12'h213});
    end
    exp_q.push_back({4'hB, 4'hA, 4'hC});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_back_to_back", {19'd0, out_valid, out_a, out_b, out_c}, {19'd0, 1'b1, 12'hBAC});
    drain();
    chk("bp_cnt", {24'd0, frame_cnt}, 3);

    // Flush mid-frame drops the partial triple and the offered word.
    send_word(4'h7);
    send_word(4'h8);
    in_data  = 4'hF;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    send_word(4'h4);
    send_word(4'h6);
    exp_q.push_back({4'h6, 4'h4, 4'hE});
    send_word(4'hE);
    in_valid = 1'b0;
    drain();
    chk("flush_cnt", {24'd0, frame_cnt}, 4);

    // Asynchronous reset while a triple is pending (never delivered).
    out_ready = 1'b0;
    send_word(4'h1);
    send_word(4'h2);
    send_word(4'h3);
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'd0, out_valid}, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_out", {20'd0, out_a, out_b, out_c}, 0);
    chk("async_reset_valid_cnt", {23'd0, out_valid, frame_cnt}, 0);
    chk("async_reset_in_ready", {31'd0, in_ready}, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of a frame.
    out_ready = 1'b1;
    send_word(4'h1);
    send_word(4'h2);
    in_valid = 1'b0;
    pulse_rst();
    send_word(4'hC);
    send_word(4'hD);
    exp_q.push_back({4'hD, 4'hC, 4'hE});
    send_word(4'hE);
    in_valid = 1'b0;
    drain();
    chk("reset_mid_frame_cnt", {24'd0, frame_cnt}, 1);

    // Full-rate stream of 256 triples: counter wraps, one pulse per 3 cycles.
    pulse_rst();
    gap_en = 1;
    d0 = del_cnt;
    t0 = cyc;
    for (int unsigned k = 0; k < 256; k++) begin
      a = 4'(k);
      b = 4'(k * 7);
      c = 4'(k + 5);
      exp_q.push_back({b, a, c});
      send_word(a);
      send_word(b);
      send_word(c);
    end
    in_valid = 1'b0;
    chk("stream_cycles", cyc - t0, 768);
    drain();
    gap_en = 0;
    chk("stream_deliveries", del_cnt - d0, 256);
    chk("wrap_cnt", {24'd0, frame_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
